int_sequencer: RTL and testbench

Interrupt entry sequencer for the 5-stage pipelined core; sits beside the hazard unit and PC/stack logic.
- Detects a rising edge on the external interrupt and waits for a safe pipeline point: no stall, no flush, no 2-byte operand in flight.
- Freezes fetch, squashes the instruction in IF/ID, and drains older in-flight instructions.
- Pushes the return PC on the stack through the shared data-memory port, then loads the PC from the interrupt vector.
- Tracks in-service status until RTI retires.

---
 rtl/int_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_int_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: waits for a safe pipeline point, drains older
// instructions, pushes the return PC and loads the PC from the interrupt vector.
module int_sequencer #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] VEC_ADDR     = 8'h01,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            intr_in,
  input  logic            hu_stall,
  input  logic            hu_flush,
  input  logic [3:0]      id_ex_opcode,
  input  logic [PC_W-1:0] if_id_pc,
  input  logic            br_redirect,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] sp_in,
  input  logic            mem_gnt,
  input  logic [PC_W-1:0] mem_rdata,
  input  logic            rti_retire,
  output logic            pc_hold,
  output logic            pipe_flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] mem_wdata,
  output logic            sp_dec,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_val,
  output logic            in_service,
  output logic            busy
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       OPC_OPERAND = 4'd12;
  localparam logic [PC_W-1:0]  PC_ZERO     = {PC_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PUSH    = 3'd3,
    ST_VEC     = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              intr_q_r;
  logic              pending_r;
  logic              in_service_r;
  logic [PC_W-1:0]   ret_pc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              hold_r;
  logic              flush_r;
  logic              req_r;
  logic              we_r;
  logic              busy_r;

  logic              edge_s;
  logic              entry_ok_s;
  logic              clr_pending_s;
  logic              push_done_s;
  logic              vec_done_s;

  assign edge_s     = intr_in & ~intr_q_r;
  // Safe point: no stall, no flush, and IF/ID is not an operand byte.
  assign entry_ok_s = pending_r & ~in_service_r & ~hu_stall & ~hu_flush &
                      (id_ex_opcode != OPC_OPERAND);

  // Next-state decode and grant-qualified strobes.
  always_comb begin
    state_s       = state_r;
    clr_pending_s = 1'b0;
    push_done_s   = 1'b0;
    vec_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (entry_ok_s) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        state_s       = ST_DRAIN;
        clr_pending_s = 1'b1;
      end
      ST_DRAIN: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_PUSH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_PUSH: begin
        if (mem_gnt) begin
          push_done_s = 1'b1;
          state_s     = ST_VEC;
        end else begin
          state_s = ST_PUSH;
        end
      end
      ST_VEC: begin
        if (mem_gnt) begin
          vec_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_VEC;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered state-decoded strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      hold_r  <= 1'b0;
      flush_r <= 1'b0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= (state_s != ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      flush_r <= (state_s == ST_CAPTURE) || (state_s == ST_DRAIN);
      req_r   <= (state_s == ST_PUSH) || (state_s == ST_VEC);
      we_r    <= (state_s == ST_PUSH);
    end
  end

  // Edge detect; a new edge wins over the capture-time clear so it is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      intr_q_r  <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      intr_q_r  <= intr_in;
      pending_r <= (pending_r & ~clr_pending_s) | edge_s;
    end
  end

  // In-service flag: set on vector load, cleared by a retiring RTI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_service_r <= 1'b0;
    end else if (vec_done_s) begin
      in_service_r <= 1'b1;
    end else if (rti_retire && in_service_r) begin
      in_service_r <= 1'b0;
    end else begin
      in_service_r <= in_service_r;
    end
  end

  // Return PC capture with drain-time branch redirect, and drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_pc_r <= PC_ZERO;
      cnt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_CAPTURE: begin
          ret_pc_r <= if_id_pc;
          cnt_r    <= DRAIN_LOAD;
        end
        ST_DRAIN: begin
          if (br_redirect) begin
            ret_pc_r <= br_target;
          end else begin
            ret_pc_r <= ret_pc_r;
          end
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          ret_pc_r <= ret_pc_r;
          cnt_r    <= cnt_r;
        end
      endcase
    end
  end

  assign pc_hold     = hold_r;
  assign pipe_flush  = flush_r;
  assign mem_req     = req_r;
  assign mem_we      = we_r;
  assign busy        = busy_r;
  assign in_service  = in_service_r;
  assign sp_dec      = push_done_s;
  assign pc_load     = vec_done_s;
  assign pc_load_val = vec_done_s ? mem_rdata : PC_ZERO;
  assign mem_wdata   = we_r ? ret_pc_r : PC_ZERO;
  assign mem_addr    = we_r ? sp_in : (req_r ? VEC_ADDR : PC_ZERO);

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: per-cycle stimulus tables compared
// against an event-timeline model derived from the entry rules.
module tb_int_sequencer;

  localparam int         N   = 96;
  localparam int         D   = 3;
  localparam logic [7:0] VEC = 8'h01;

  typedef struct packed {
    logic       hold;
    logic       flush;
    logic       req;
    logic       we;
    logic       spdec;
    logic       load;
    logic       ins;
    logic       busy;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] lval;
  } obs_t;

  logic       clk;
  logic       rst_n, intr_in, hu_stall, hu_flush, br_redirect, mem_gnt, rti_retire;
  logic [3:0] id_ex_opcode;
  logic [7:0] if_id_pc, br_target, sp_in, mem_rdata;
  logic       pc_hold, pipe_flush, mem_req, mem_we, sp_dec, pc_load, in_service, busy;
  logic [7:0] mem_addr, mem_wdata, pc_load_val;

  int_sequencer #(.PC_W(8), .VEC_ADDR(8'h01), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .intr_in(intr_in), .hu_stall(hu_stall),
    .hu_flush(hu_flush), .id_ex_opcode(id_ex_opcode), .if_id_pc(if_id_pc),
    .br_redirect(br_redirect), .br_target(br_target), .sp_in(sp_in),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .rti_retire(rti_retire),
    .pc_hold(pc_hold), .pipe_flush(pipe_flush), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sp_dec(sp_dec), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .in_service(in_service), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-cycle stimulus tables
  logic       st_rst [N];
  logic       st_intr[N];
  logic       st_stall[N];
  logic       st_flush[N];
  logic       st_op12[N];
  logic       st_br  [N];
  logic       st_gnt [N];
  logic       st_rti [N];
  logic [7:0] st_pc  [N];
  logic [7:0] st_bt  [N];
  logic [7:0] st_rd  [N];
  logic [7:0] sp_val;
  int         ev[2];
  int         nev;

  obs_t       exp_v[N];
  obs_t       obs_v[N];
  int         cap_c[2], push_c[2], vec_c[2], rti_c[2];
  logic [7:0] ret_v[2];

  int checks = 0;
  int errors = 0;

  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      st_rst[c] = 1'b0; st_intr[c] = 1'b0; st_stall[c] = 1'b0; st_flush[c] = 1'b0;
      st_op12[c] = 1'b0; st_br[c] = 1'b0; st_gnt[c] = 1'b1; st_rti[c] = 1'b0;
      st_pc[c] = 8'h00; st_bt[c] = 8'h00; st_rd[c] = 8'h00;
    end
    sp_val = 8'h00;
    nev = 0;
  endtask

  function automatic bit safe_at(int c);
    return !st_stall[c] && !st_flush[c] && !st_op12[c];
  endfunction

  // Timeline model: each entry's capture / push-grant / vector-grant / RTI
  // cycle is found by scanning the tables, then expected outputs are painted.
  task automatic build_expect();
    int c, start;
    logic [7:0] ret;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = '0;
      st_intr[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      cap_c[k] = -1; push_c[k] = N; vec_c[k] = N; rti_c[k] = N; ret_v[k] = 8'h00;
    end
    for (int k = 0; k < nev; k++) if (ev[k] < N) st_intr[ev[k]] = 1'b1;
    start = 0;
    for (int k = 0; k < nev; k++) begin
      c = (ev[k] + 1 > start) ? ev[k] + 1 : start;
      while (c < N && !safe_at(c)) c++;
      if (c >= N - 1) break;
      cap_c[k] = c + 1;
      ret = st_pc[c + 1];
      for (int j = c + 2; j <= c + 1 + D && j < N; j++) if (st_br[j]) ret = st_bt[j];
      ret_v[k] = ret;
      c = cap_c[k] + D + 1;
      while (c < N && !st_gnt[c]) c++;
      push_c[k] = c;
      c = c + 1;
      while (c < N && !st_gnt[c]) c++;
      vec_c[k] = c;
      c = c + 1;
      while (c < N && !st_rti[c]) c++;
      rti_c[k] = c;
      start = c + 1;
    end
    for (int k = 0; k < nev; k++) begin
      if (cap_c[k] >= 0) begin
        for (int j = cap_c[k]; j < N && j <= vec_c[k]; j++) begin
          exp_v[j].hold = 1'b1; exp_v[j].busy = 1'b1;
        end
        for (int j = cap_c[k]; j < N && j <= cap_c[k] + D; j++) exp_v[j].flush = 1'b1;
        for (int j = cap_c[k] + D + 1; j < N && j <= push_c[k]; j++) begin
          exp_v[j].req = 1'b1; exp_v[j].we = 1'b1;
          exp_v[j].addr = sp_val; exp_v[j].wd = ret_v[k];
        end
        if (push_c[k] < N) exp_v[push_c[k]].spdec = 1'b1;
        for (int j = push_c[k] + 1; j < N && j <= vec_c[k]; j++) begin
          exp_v[j].req = 1'b1; exp_v[j].addr = VEC;
        end
        if (vec_c[k] < N) begin
          exp_v[vec_c[k]].load = 1'b1; exp_v[vec_c[k]].lval = st_rd[vec_c[k]];
        end
        for (int j = vec_c[k] + 1; j < N && j <= rti_c[k]; j++) exp_v[j].ins = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; intr_in = 1'b0; hu_stall = 1'b0; hu_flush = 1'b0;
    id_ex_opcode = 4'd0; if_id_pc = 8'h00; br_redirect = 1'b0; br_target = 8'h00;
    sp_in = 8'h00; mem_gnt = 1'b0; mem_rdata = 8'h00; rti_retire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_stim();
    for (int c = 0; c < N; c++) begin
      rst_n = !st_rst[c]; intr_in = st_intr[c]; hu_stall = st_stall[c];
      hu_flush = st_flush[c]; id_ex_opcode = st_op12[c] ? 4'd12 : 4'd3;
      if_id_pc = st_pc[c]; br_redirect = st_br[c]; br_target = st_bt[c];
      sp_in = sp_val; mem_gnt = st_gnt[c]; mem_rdata = st_rd[c]; rti_retire = st_rti[c];
      @(negedge clk);
      obs_v[c].hold = pc_hold;  obs_v[c].flush = pipe_flush; obs_v[c].req = mem_req;
      obs_v[c].we = mem_we;     obs_v[c].spdec = sp_dec;     obs_v[c].load = pc_load;
      obs_v[c].ins = in_service; obs_v[c].busy = busy;       obs_v[c].addr = mem_addr;
      obs_v[c].wd = mem_wdata;  obs_v[c].lval = pc_load_val;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    intr_in = 1'b1; mem_gnt = 1'b1; sp_in = 8'hFF; rti_retire = 1'b1; mem_rdata = 8'h55;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pc_hold, pipe_flush, mem_req, mem_we, sp_dec, pc_load, in_service, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000000",
               {pc_hold, pipe_flush, mem_req, mem_we, sp_dec, pc_load, in_service, busy});
    end
    checks++;
    if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_addr); end
    checks++;
    if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", mem_wdata); end
    checks++;
    if (pc_load_val !== 8'h00) begin errors++; $display("FAIL reset_lval got %h want 00", pc_load_val); end
  endtask

  task automatic test_basic();
    int first_busy, load_at;
    clear_stim();
    sp_val = 8'hFF;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h12; st_rd[c] = 8'h40; end
    ev[0] = 2; nev = 1;
    build_expect();
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL basic_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    first_busy = -1; load_at = -1;
    for (int c = 0; c < N; c++) begin
      if (obs_v[c].busy && first_busy < 0) first_busy = c;
      if (obs_v[c].load && load_at < 0) load_at = c;
    end
    checks++;
    if (first_busy != 4) begin errors++; $display("FAIL basic_capture_cycle got %0d want 4", first_busy); end
    // CAPTURE is cycle 1 of the sequence, pc_load lands in cycle 1+3+2 = 6
    checks++;
    if (load_at - first_busy != 5) begin
      errors++; $display("FAIL basic_latency got %0d want 5", load_at - first_busy);
    end
    checks++;
    if (!(obs_v[8].we && obs_v[8].spdec && obs_v[8].addr == 8'hFF && obs_v[8].wd == 8'h12)) begin
      errors++; $display("FAIL basic_push got addr %h data %h want addr ff data 12", obs_v[8].addr, obs_v[8].wd);
    end
    checks++;
    if (obs_v[9].lval !== 8'h40) begin errors++; $display("FAIL basic_vector got %h want 40", obs_v[9].lval); end
    checks++;
    if (obs_v[10].ins !== 1'b1) begin errors++; $display("FAIL basic_in_service got %b want 1", obs_v[10].ins); end
  endtask

  task automatic test_blocked();
    int first_busy;
    clear_stim();
    sp_val = 8'hF0;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h20 + 8'(c); st_rd[c] = 8'h44; end
    for (int c = 3; c <= 5; c++) st_stall[c] = 1'b1;
    st_op12[6] = 1'b1;
    ev[0] = 2; nev = 1;
    build_expect();
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL blocked_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    first_busy = -1;
    for (int c = 0; c < N; c++) if (obs_v[c].busy && first_busy < 0) first_busy = c;
    checks++;
    if (first_busy != 8) begin errors++; $display("FAIL blocked_capture_cycle got %0d want 8", first_busy); end
  endtask

  task automatic test_redirect();
    clear_stim();
    sp_val = 8'hFE;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h12; st_rd[c] = 8'h40; end
    st_br[6] = 1'b1; st_bt[6] = 8'h30;
    ev[0] = 2; nev = 1;
    build_expect();
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL redirect_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[8].wd !== 8'h30) begin errors++; $display("FAIL redirect_push_data got %h want 30", obs_v[8].wd); end
  endtask

  task automatic test_grant_wait();
    int n_dec, n_load;
    clear_stim();
    sp_val = 8'hC0;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h5A; st_rd[c] = 8'h77; end
    for (int c = 8; c <= 11; c++) st_gnt[c] = 1'b0;
    st_gnt[13] = 1'b0; st_gnt[14] = 1'b0;
    ev[0] = 2; nev = 1;
    build_expect();
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL gntwait_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    n_dec = 0; n_load = 0;
    for (int c = 0; c < N; c++) begin
      if (obs_v[c].spdec) n_dec++;
      if (obs_v[c].load) n_load++;
    end
    checks++;
    if (n_dec != 1) begin errors++; $display("FAIL gntwait_sp_dec_pulses got %0d want 1", n_dec); end
    checks++;
    if (n_load != 1 || !obs_v[15].load) begin
      errors++; $display("FAIL gntwait_pc_load got %0d pulses want 1 at cycle 15", n_load);
    end
  endtask

  task automatic test_no_nesting();
    int early;
    clear_stim();
    sp_val = 8'hA0;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h33; st_rd[c] = 8'h60; end
    st_rti[5] = 1'b1;
    st_rti[30] = 1'b1;
    ev[0] = 2; ev[1] = 15; nev = 2;
    build_expect();
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL nonest_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    early = 0;
    for (int c = 10; c <= 31; c++) if (obs_v[c].busy) early++;
    checks++;
    if (early != 0) begin errors++; $display("FAIL nonest_entry_while_in_service got %0d busy cycles want 0", early); end
    checks++;
    if (obs_v[30].ins !== 1'b1 || obs_v[31].ins !== 1'b0) begin
      errors++; $display("FAIL nonest_rti_clear got %b%b want 10", obs_v[30].ins, obs_v[31].ins);
    end
    checks++;
    if (obs_v[32].busy !== 1'b1) begin errors++; $display("FAIL nonest_second_entry got %b want 1", obs_v[32].busy); end
  endtask

  task automatic test_reset_mid_push();
    clear_stim();
    sp_val = 8'h90;
    for (int c = 0; c < N; c++) begin st_pc[c] = 8'h21; st_rd[c] = 8'h50; end
    for (int c = 8; c <= 20; c++) st_gnt[c] = 1'b0;
    ev[0] = 2; nev = 1;
    build_expect();
    st_intr[6] = 1'b1;
    st_rst[10] = 1'b1;
    for (int c = 11; c < N; c++) exp_v[c] = '0;
    do_reset(); run_stim();
    for (int c = 0; c < N; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        errors++; $display("FAIL rstpush_cyc%0d got %h want %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[10].we !== 1'b1 || obs_v[11] !== obs_t'(0)) begin
      errors++; $display("FAIL rstpush_abandon got we %b next %h want 1 and 0", obs_v[10].we, obs_v[11]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      sp_val = 8'($urandom);
      for (int c = 0; c < N; c++) begin
        st_pc[c]    = 8'($urandom);
        st_bt[c]    = 8'($urandom);
        st_rd[c]    = 8'($urandom);
        st_stall[c] = ($urandom_range(0, 9) < 3);
        st_flush[c] = ($urandom_range(0, 9) < 2);
        st_op12[c]  = ($urandom_range(0, 9) < 2);
        st_br[c]    = ($urandom_range(0, 9) < 3);
        st_gnt[c]   = ($urandom_range(0, 9) < 6);
        st_rti[c]   = ($urandom_range(0, 9) < 2);
      end
      ev[0] = int'($urandom_range(0, 6)); nev = 1;
      build_expect();
      if (cap_c[0] >= 0 && $urandom_range(0, 1) == 1) begin
        ev[1] = cap_c[0] + int'($urandom_range(0, 12)); nev = 2;
        build_expect();
      end
      do_reset(); run_stim();
      for (int c = 0; c < N; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c]) begin
          errors++; $display("FAIL random%0d_cyc%0d got %h want %h", it, c, obs_v[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blocked();
    test_redirect();
    test_grant_wait();
    test_no_nesting();
    test_reset_mid_push();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
